coin_accumulator: RTL and testbench

Payment stage of the Lab4 coffee machine. Sits between the coin buttons and the brewing FSM, alongside the drink-selection register and cost lookup. It accepts coins while a drink is selected and keeps a running total. When the total covers the drink cost it asserts `paid` to start serving and reports the change owed. It clears when serving finishes or the customer cancels.

---
 rtl/coin_accumulator.sv | 124 ++++++++++++
 tb/tb_coin_accumulator.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_accumulator.sv
// Coin payment stage: synchronises raw buttons, accumulates credit, authorises serving.
// Optional macro COIN_CHANGE_EN enables the change output (tied to 0 otherwise).
module coin_accumulator #(
  parameter int unsigned W      = 5,
  parameter int unsigned COIN_A = 1,
  parameter int unsigned COIN_B = 2,
  parameter int unsigned COIN_C = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   coin_n,
  input  logic         cancel_n,
  input  logic         sel_valid,
  input  logic [3:0]   cost,
  input  logic         serve_done,
  output logic [W-1:0] total,
  output logic         paid,
  output logic [W-1:0] change,
  output logic [W-1:0] refund,
  output logic         refund_vld,
  output logic         coin_reject
);

  typedef enum logic [1:0] {StIdle, StCollect, StPaid, StRefund} state_e;
  state_e state;

  // Bit 3 is cancel, bits 2:0 are coins A..C.
  logic [3:0] sync1, sync2, prev;
  logic [3:0] fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
    end else begin
      sync1 <= {cancel_n, coin_n};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign fall = prev & ~sync2;

  logic         coin_evt, cancel_evt, add_ok, reach;
  logic [W:0]   coin_val, sum;
  logic [W-1:0] new_total;

  always_comb begin
    coin_val = '0;
    if (fall[2])      coin_val = (W+1)'(COIN_C);
    else if (fall[1]) coin_val = (W+1)'(COIN_B);
    else if (fall[0]) coin_val = (W+1)'(COIN_A);
  end

  assign coin_evt   = |fall[2:0];
  assign cancel_evt = fall[3];
  assign sum        = {1'b0, total} + coin_val;
  // A carry into bit W means the coin would push the total past 2^W-1.
  assign add_ok     = coin_evt && !sum[W];
  assign new_total  = add_ok ? sum[W-1:0] : total;
  assign reach      = (cost != 4'd0) && ({1'b0, new_total} >= (W+1)'(cost));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      total       <= '0;
      change      <= '0;
      refund      <= '0;
      paid        <= 1'b0;
      refund_vld  <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      coin_reject <= 1'b0;
      refund_vld  <= 1'b0;
      case (state)
        StIdle: begin
          total  <= '0;
          change <= '0;
          paid   <= 1'b0;
          if (coin_evt) coin_reject <= 1'b1;
          if (sel_valid && cost != 4'd0) state <= StCollect;
        end
        StCollect: begin
          if (coin_evt && !add_ok) coin_reject <= 1'b1;
          total <= new_total;
          // Reaching the cost takes priority over a simultaneous cancel.
          if (reach) begin
            state <= StPaid;
            paid  <= 1'b1;
`ifdef COIN_CHANGE_EN
            change <= new_total - W'(cost);
`else
            change <= '0;
`endif
          end else if (cancel_evt || (!sel_valid && new_total != '0)) begin
            state      <= StRefund;
            refund     <= new_total;
            refund_vld <= 1'b1;
          end else if (!sel_valid) begin
            state <= StIdle;
          end
        end
        StPaid: begin
          if (coin_evt) coin_reject <= 1'b1;
          if (serve_done) begin
            state  <= StIdle;
            total  <= '0;
            change <= '0;
            paid   <= 1'b0;
          end
        end
        StRefund: begin
          if (coin_evt) coin_reject <= 1'b1;
          total  <= '0;
          refund <= '0;
          state  <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_accumulator.sv
// Directed bench for coin_accumulator; a second W=4 instance shares stimulus for overflow.
module tb_coin_accumulator;

`ifdef COIN_CHANGE_EN
  localparam bit ChgEn = 1'b1;
`else
  localparam bit ChgEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] coin_n = 3'b111;
  logic       cancel_n = 1'b1;
  logic       sel_valid = 1'b0;
  logic [3:0] cost = 4'd0;
  logic       serve_done = 1'b0;

  logic [4:0] total, change, refund;
  logic       paid, refund_vld, coin_reject;
  logic [3:0] t4_total, t4_change, t4_refund;
  logic       t4_paid, t4_refund_vld, t4_coin_reject;

  int checks = 0;
  int bad = 0;

  always #5 clk = ~clk;

  coin_accumulator #(.W(5)) u_dut (
    .clk(clk), .rst(rst), .coin_n(coin_n), .cancel_n(cancel_n), .sel_valid(sel_valid),
    .cost(cost), .serve_done(serve_done), .total(total), .paid(paid), .change(change),
    .refund(refund), .refund_vld(refund_vld), .coin_reject(coin_reject)
  );

  coin_accumulator #(.W(4)) u_dut_w4 (
    .clk(clk), .rst(rst), .coin_n(coin_n), .cancel_n(cancel_n), .sel_valid(sel_valid),
    .cost(cost), .serve_done(serve_done), .total(t4_total), .paid(t4_paid),
    .change(t4_change), .refund(t4_refund), .refund_vld(t4_refund_vld),
    .coin_reject(t4_coin_reject)
  );

  // Drive a press; returns just after the edge on which the event is accumulated.
  task automatic press(input logic [2:0] coins, input logic cxl);
    @(negedge clk);
    coin_n   = ~coins;
    cancel_n = ~cxl;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic release_btns();
    coin_n   = 3'b111;
    cancel_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic serve();
    @(negedge clk);
    serve_done = 1'b1;
    @(posedge clk);
    #1;
    serve_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({total, paid, change, refund, refund_vld, coin_reject} !== 18'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0",
               {total, paid, change, refund, refund_vld, coin_reject});
    end
  endtask

  task automatic test_exact_pay();
    sel_valid = 1'b1;
    cost      = 4'd4;
    press(3'b010, 1'b0);
    checks++;
    if (total !== 5'd2 || paid !== 1'b0) begin
      bad++; $display("FAIL b1_total got=%0d/%0b want=2/0", total, paid);
    end
    release_btns();
    press(3'b010, 1'b0);
    checks++;
    if (total !== 5'd4 || paid !== 1'b1 || change !== 5'd0) begin
      bad++; $display("FAIL b2_paid got=%0d/%0b/%0d want=4/1/0", total, paid, change);
    end
    release_btns();
    serve();
    checks++;
    if (total !== 5'd0 || paid !== 1'b0) begin
      bad++; $display("FAIL serve_clear got=%0d/%0b want=0/0", total, paid);
    end
  endtask

  task automatic test_change();
    cost = 4'd3;
    press(3'b100, 1'b0);
    checks++;
    if (total !== 5'd5 || paid !== 1'b1 || change !== (ChgEn ? 5'd2 : 5'd0)) begin
      bad++; $display("FAIL c_change got=%0d/%0b/%0d want=5/1/%0d", total, paid, change,
                      ChgEn ? 2 : 0);
    end
    release_btns();
    press(3'b001, 1'b0);
    checks++;
    if (coin_reject !== 1'b1 || total !== 5'd5) begin
      bad++; $display("FAIL paid_reject got=%0b/%0d want=1/5", coin_reject, total);
    end
    @(posedge clk); #1;
    checks++;
    if (coin_reject !== 1'b0) begin
      bad++; $display("FAIL reject_width got=%0b want=0", coin_reject);
    end
    release_btns();
    serve();
  endtask

  task automatic test_cancel();
    cost = 4'd7;
    press(3'b001, 1'b0);
    release_btns();
    press(3'b010, 1'b0);
    release_btns();
    press(3'b000, 1'b1);
    checks++;
    if (refund_vld !== 1'b1 || refund !== 5'd3) begin
      bad++; $display("FAIL cancel_refund got=%0b/%0d want=1/3", refund_vld, refund);
    end
    @(posedge clk); #1;
    checks++;
    if (refund_vld !== 1'b0 || total !== 5'd0) begin
      bad++; $display("FAIL refund_end got=%0b/%0d want=0/0", refund_vld, total);
    end
    release_btns();
  endtask

  task automatic test_idle_reject();
    sel_valid = 1'b0;
    repeat (2) @(posedge clk);
    press(3'b001, 1'b0);
    checks++;
    if (coin_reject !== 1'b1 || total !== 5'd0) begin
      bad++; $display("FAIL idle_reject got=%0b/%0d want=1/0", coin_reject, total);
    end
    release_btns();
  endtask

  task automatic test_overflow();
    do_reset();
    sel_valid = 1'b1;
    cost      = 4'd15;
    for (int i = 0; i < 2; i++) begin press(3'b100, 1'b0); release_btns(); end
    for (int i = 0; i < 2; i++) begin press(3'b010, 1'b0); release_btns(); end
    checks++;
    if (total !== 5'd14 || t4_total !== 4'd14 || paid !== 1'b0) begin
      bad++; $display("FAIL pre_ovf got=%0d/%0d/%0b want=14/14/0", total, t4_total, paid);
    end
    press(3'b100, 1'b0);
    checks++;
    if (t4_coin_reject !== 1'b1 || t4_total !== 4'd14 || t4_paid !== 1'b0) begin
      bad++; $display("FAIL w4_ovf got=%0b/%0d/%0b want=1/14/0",
                      t4_coin_reject, t4_total, t4_paid);
    end
    checks++;
    if (total !== 5'd19 || paid !== 1'b1 || change !== (ChgEn ? 5'd4 : 5'd0)) begin
      bad++; $display("FAIL over_pay got=%0d/%0b/%0d want=19/1/%0d", total, paid, change,
                      ChgEn ? 4 : 0);
    end
    release_btns();
    press(3'b001, 1'b0);
    checks++;
    if (t4_total !== 4'd15 || t4_paid !== 1'b1 || coin_reject !== 1'b1) begin
      bad++; $display("FAIL w4_fill got=%0d/%0b/%0b want=15/1/1", t4_total, t4_paid,
                      coin_reject);
    end
    release_btns();
    serve();
  endtask

  task automatic test_fill_15();
    for (int i = 0; i < 3; i++) begin
      press(3'b100, 1'b0);
      checks++;
      if (total !== 5'(5 * (i + 1)) || paid !== (i == 2)) begin
        bad++; $display("FAIL fill_c%0d got=%0d/%0b want=%0d/%0b", i, total, paid,
                        5 * (i + 1), i == 2);
      end
      release_btns();
    end
    serve();
  endtask

  task automatic test_simultaneous();
    press(3'b101, 1'b0);
    checks++;
    if (total !== 5'd5 || coin_reject !== 1'b0) begin
      bad++; $display("FAIL simul_ac got=%0d/%0b want=5/0", total, coin_reject);
    end
    release_btns();
    // Coin and cancel together: coin is counted into the refund.
    press(3'b001, 1'b1);
    checks++;
    if (refund_vld !== 1'b1 || refund !== 5'd6) begin
      bad++; $display("FAIL coin_cancel got=%0b/%0d want=1/6", refund_vld, refund);
    end
    release_btns();
  endtask

  task automatic test_hold_and_rst();
    @(negedge clk);
    coin_n = 3'b110;
    repeat (20) @(posedge clk);
    #1;
    release_btns();
    checks++;
    if (total !== 5'd1) begin
      bad++; $display("FAIL hold_once got=%0d want=1", total);
    end
    press(3'b010, 1'b0);
    release_btns();
    checks++;
    if (total !== 5'd3) begin
      bad++; $display("FAIL pre_rst got=%0d want=3", total);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({total, paid, change, refund, refund_vld, coin_reject} !== 18'd0) begin
      bad++; $display("FAIL mid_rst got=%h want=0",
                      {total, paid, change, refund, refund_vld, coin_reject});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (refund_vld !== 1'b0 || total !== 5'd0) begin
      bad++; $display("FAIL post_rst got=%0b/%0d want=0/0", refund_vld, total);
    end
  endtask

  initial begin
    test_reset();
    test_exact_pay();
    test_change();
    test_cancel();
    test_idle_reject();
    test_overflow();
    test_fill_15();
    test_simultaneous();
    test_hold_and_rst();
    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end

endmodule
